tt_sweep_checker: RTL and testbench

// - Sequential stimulus/capture stage wrapped around one synthesized 4-input truth-table gate netlist.
// - Drives all 2^N_IN input rows into the gate in order, waits a settle window per row,

---
 rtl/tt_sweep_checker.sv | 147 ++++++++++++++
 tb/tb_tt_sweep_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//   Stimulus/capture wrapper around one N_IN-input truth-table gate. Walks every input row in
//   ascending order, holds each row for SETTLE cycles, samples the gate output, assembles the
//   measured truth table and compares it with an expected table.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   start     in   1      sweep request, accepted only while idle
//   exp_tt    in   TT_W   expected truth table, captured on the accept edge
//   dut_out   in   1      gate output under test (synchronous to clk)
//   dut_in    out  N_IN   row drive; dut_in[N_IN-1] feeds gate input 0
//   busy      out  1      high from the accept edge until the done cycle
//   done      out  1      one-cycle pulse, results valid from this cycle
//   pass      out  1      tt_meas == exp_tt, held until the next accepted start
//   tt_meas   out  TT_W   measured table, row r stored at bit TT_W-1-r
//   mismatch  out  TT_W   tt_meas ^ exp_tt, held until the next accepted start

module tt_sweep_checker #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_tt,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   tt_meas,
    output logic [2**N_IN-1:0]   mismatch
);

    localparam int unsigned TT_W = 2**N_IN;

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("tt_sweep_checker: SETTLE must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [TT_W-1:0]   mm_q, mm_d;
    logic [TT_W-1:0]   exp_q, exp_d;

    // Row r lands at bit TT_W-1-r, which for a power-of-two table is simply ~r.
    logic [N_IN-1:0]   bit_idx;
    assign bit_idx = ~row_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        exp_d   = exp_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    row_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    tt_d    = '0;
                    pass_d  = 1'b0;
                    mm_d    = '0;
                    exp_d   = exp_tt;
                end
            end
            StSettle: begin
                if (cnt_q == 8'(SETTLE - 1)) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StSample: begin
                tt_d[bit_idx] = dut_out;
                cnt_d         = '0;
                if (row_q == {N_IN{1'b1}}) begin
                    // Drop the drive back to 0 right away so the last row is held exactly as
                    // long as every other row.
                    state_d = StDone;
                    row_d   = '0;
                end else begin
                    state_d = StSettle;
                    row_d   = row_q + 1'b1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                pass_d  = (tt_q == exp_q);
                mm_d    = tt_q ^ exp_q;
                busy_d  = 1'b0;
                row_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            mm_q    <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            exp_q   <= exp_d;
        end
    end

    assign dut_in   = row_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign tt_meas  = tt_q;
    assign mismatch = mm_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker
//   Scoreboard bench for tt_sweep_checker with default parameters (N_IN=4, SETTLE=2).
//   Expected results are queued when a sweep is started and compared when done pulses.

module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] exp_tt;
    logic        dut_out;
    logic [3:0]  dut_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt_meas;
    logic [15:0] mismatch;

    tt_sweep_checker #(
        .N_IN   (4),
        .SETTLE (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .exp_tt   (exp_tt),
        .dut_out  (dut_out),
        .dut_in   (dut_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .tt_meas  (tt_meas),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate model: row r = {in0..in3} produces bit 15-r of the gate's truth table.
    logic [15:0] gate_tt = 16'h0239;
    logic        stuck   = 1'b0;
    always_comb dut_out = stuck ? 1'b0 : gate_tt[4'd15 - dut_in];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [15:0] tt;
        logic [15:0] mm;
        logic        pass;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    // Scoreboard consumer: every done pulse must match the oldest queued sweep.
    always @(negedge clk) begin : sb_check
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("tt_meas", 32'(tt_meas), 32'(e.tt));
                chk("mismatch", 32'(mismatch), 32'(e.mm));
                chk("pass", 32'(pass), 32'(e.pass));
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("dut_in_at_done", 32'(dut_in), 32'd0);
            end
        end
    end

    function automatic exp_t mk_exp(input logic [15:0] meas, input logic [15:0] ex,
                                    input int unsigned done_cyc);
        exp_t e;
        e.tt   = meas;
        e.mm   = meas ^ ex;
        e.pass = (meas == ex);
        e.cyc  = done_cyc;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_dut_in"}, 32'(dut_in), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_tt_meas"}, 32'(tt_meas), 32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_zero(tag);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full sweep; also checks row order/hold time, busy, and that done is a single pulse.
    task automatic run_sweep(input string tag, input logic [15:0] ex, input logic [15:0] meas);
        int unsigned a;
        int          seq_bad  = 0;
        int          busy_bad = 0;
        logic        got      = 1'b0;
        @(negedge clk);
        exp_tt = ex;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = cyc;
        sb.push_back(mk_exp(meas, ex, a + 49));
        exp_tt = ~ex;  // must not affect the running sweep
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (k < 48 && dut_in !== 4'(k / 3)) seq_bad++;
            if (k == 48 && dut_in !== 4'd0) seq_bad++;
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_row_seq_errors"}, 32'(seq_bad), 32'd0);
        chk({tag, "_busy_errors"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_pass_held"}, 32'(pass), 32'(meas == ex));
        chk({tag, "_tt_held"}, 32'(tt_meas), 32'(meas));
    endtask

    initial begin
        int unsigned a;
        int          n_done;
        logic        found;

        rst    = 1'b1;
        start  = 1'b0;
        exp_tt = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // T1 golden, T2 wrong expectation, T3 stuck-at-0
        run_sweep("t1", 16'h0239, 16'h0239);
        run_sweep("t2", 16'h0238, 16'h0239);
        stuck = 1'b1;
        run_sweep("t3", 16'h0239, 16'h0000);
        stuck = 1'b0;

        // T5: start held high -> back-to-back sweeps, starts while busy ignored
        @(negedge clk);
        exp_tt = 16'h0239;
        start  = 1'b1;
        @(negedge clk);
        a = cyc;
        sb.push_back(mk_exp(16'h0239, 16'h0239, a + 49));
        sb.push_back(mk_exp(16'h0239, 16'h0239, a + 99));
        n_done = 0;
        for (int k = 0; k < 120; k++) begin
            if (done) n_done++;
            if (k == 49) chk("t5_busy_low_in_done", 32'(busy), 32'd0);
            if (k == 50) chk("t5_busy_rises_after_done", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("t5_done_count", 32'(n_done), 32'd2);
        do_reset("t5_abort");

        // T6: reset while dut_in == 7, no done afterwards, then a clean golden sweep
        @(negedge clk);
        exp_tt = 16'h0239;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb.push_back(mk_exp(16'h0239, 16'h0239, cyc + 49));
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dut_in == 4'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_reached_row7", 32'(found), 32'd1);
        do_reset("t6_mid_reset");
        repeat (60) @(negedge clk);  // any done here hits an empty scoreboard
        chk("t6_idle_busy", 32'(busy), 32'd0);
        run_sweep("t6_rerun", 16'h0239, 16'h0239);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
